mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_pkg.sv | 21 ++
 rtl/rr_arbiter2.sv | 17 +
 rtl/mem_arbiter.sv | 112 +++++++++++
 tb/tb_mem_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared command and state encodings for the memory arbiter.
// No logic; constants, state enum and a command-decode helper only.
// Not applicable: no handshakes live here.
package mem_pkg;

   localparam logic [1:0] MNONE  = 2'b00;
   localparam logic [1:0] MREAD  = 2'b01;
   localparam logic [1:0] MWRITE = 2'b10;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      RESP   = 2'b10
   } state_t;

   // 2'b11 is reserved and decodes the same as MNONE.
   function automatic logic cmd_vld(input logic [1:0] cmd);
      return (cmd == MREAD) || (cmd == MWRITE);
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the port not granted last.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the grant is consumed.
module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last_b,
   output logic [1:0] grant
);

   // Bit 0 is port A, bit 1 is port B; at most one bit is ever set.
   always_comb begin
      grant    = 2'b00;
      grant[0] = req[0] & (~req[1] | last_b);
      grant[1] = req[1] & (~req[0] | ~last_b);
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto one single-port-style RAM, one transaction at a time.
// Latency: fixed 3 cycles per transaction (IDLE sample, ACCESS, RESP with ack).
// Backpressure: requesters hold their request until ack; inputs are only sampled in IDLE.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        a_cmd,
   input  logic [ADDR_W:0]   a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   input  logic [1:0]        b_cmd,
   input  logic [ADDR_W:0]   b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              a_ack,
   output logic              b_ack,
   output logic [DATA_W-1:0] rdata,
   output logic              err,
   output logic              busy,
   output logic [ADDR_W-1:0] ram_read_address,
   output logic [ADDR_W-1:0] ram_write_address,
   output logic              ram_write,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout
);

   state_t            state_q;
   state_t            state_d;
   logic [1:0]        grant_q;
   logic              last_b_q;
   logic [ADDR_W:0]   addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [1:0]        cmd_q;

   logic [1:0]        req_vld;
   logic [1:0]        arb_grant;
   logic              start;
   logic              unmapped;

   assign req_vld  = {cmd_vld(b_cmd), cmd_vld(a_cmd)};
   assign start    = (state_q == IDLE) && (|req_vld);
   assign unmapped = addr_q[ADDR_W];

   rr_arbiter2 u_rr (
      .req    (req_vld),
      .last_b (last_b_q),
      .grant  (arb_grant)
   );

   // Both RAM address ports follow the latched request address.
   assign ram_read_address  = addr_q[ADDR_W-1:0];
   assign ram_write_address = addr_q[ADDR_W-1:0];
   assign ram_din           = wdata_q;

   // State register; reset abandons any in-flight transaction without an ack.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Capture the winning request in IDLE; last_b starts at B so A takes the first tie.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         grant_q  <= 2'b00;
         last_b_q <= 1'b1;
         addr_q   <= '0;
         wdata_q  <= '0;
         cmd_q    <= MNONE;
      end else if (start) begin
         grant_q  <= arb_grant;
         last_b_q <= arb_grant[1];
         addr_q   <= arb_grant[0] ? a_addr  : b_addr;
         wdata_q  <= arb_grant[0] ? a_wdata : b_wdata;
         cmd_q    <= arb_grant[0] ? a_cmd   : b_cmd;
      end
   end

   // Next state and outputs, all decoded from registered state and the RAM's registered dout.
   always_comb begin
      state_d   = state_q;
      ram_write = 1'b0;
      a_ack     = 1'b0;
      b_ack     = 1'b0;
      err       = 1'b0;
      rdata     = '0;
      busy      = (state_q != IDLE);
      case (state_q)
         IDLE: begin
            if (|req_vld) state_d = ACCESS;
         end
         ACCESS: begin
            ram_write = (cmd_q == MWRITE) && !unmapped;
            state_d   = RESP;
         end
         RESP: begin
            a_ack   = grant_q[0];
            b_ack   = grant_q[1];
            err     = unmapped;
            if ((cmd_q == MREAD) && !unmapped) rdata = ram_dout;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 1-cycle-latency RAM and a completion scoreboard.
// Latency: each directed step waits a fixed, known number of cycles.
// Backpressure: requests are held until the expected ack cycle, then dropped.
module tb_mem_arbiter;
   import mem_pkg::*;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 8;

   logic              clk;
   logic              reset_n;
   logic [1:0]        a_cmd, b_cmd;
   logic [ADDR_W:0]   a_addr, b_addr;
   logic [DATA_W-1:0] a_wdata, b_wdata;
   logic              a_ack, b_ack, err, busy, ram_write;
   logic [DATA_W-1:0] rdata, ram_din, ram_dout;
   logic [ADDR_W-1:0] ram_read_address, ram_write_address;

   typedef struct {
      bit                port_b;
      logic [DATA_W-1:0] rdata;
      bit                err;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   ack_times[$];
   int   checks = 0;
   int   errors = 0;
   int   wr_cnt = 0;
   int   cyc_cnt = 0;
   int   w0;

   logic [DATA_W-1:0] mem [256] = '{default: 16'h0};

   mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .a_cmd             (a_cmd),
      .a_addr            (a_addr),
      .a_wdata           (a_wdata),
      .b_cmd             (b_cmd),
      .b_addr            (b_addr),
      .b_wdata           (b_wdata),
      .a_ack             (a_ack),
      .b_ack             (b_ack),
      .rdata             (rdata),
      .err               (err),
      .busy              (busy),
      .ram_read_address  (ram_read_address),
      .ram_write_address (ram_write_address),
      .ram_write         (ram_write),
      .ram_din           (ram_din),
      .ram_dout          (ram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural RAM: synchronous write, registered read.
   always @(posedge clk) begin
      if (ram_write) mem[ram_write_address] <= ram_din;
      ram_dout <= mem[ram_read_address];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Completion monitor: every ack pops one scoreboard entry and is compared against it.
   always @(negedge clk) begin
      cyc_cnt++;
      if (reset_n) begin
         if (ram_write) wr_cnt++;
         if (a_ack || b_ack) begin
            check("single_ack", 32'(a_ack & b_ack), 32'd0);
            check("ack_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               mon_e = exp_q.pop_front();
               check("ack_port_b", 32'(b_ack), 32'(mon_e.port_b));
               check("ack_rdata", 32'(rdata), 32'(mon_e.rdata));
               check("ack_err", 32'(err), 32'(mon_e.err));
            end
            ack_times.push_back(cyc_cnt);
         end
      end
   end

   initial begin
      reset_n = 1'b0;
      a_cmd = MNONE; a_addr = '0; a_wdata = '0;
      b_cmd = MNONE; b_addr = '0; b_wdata = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ram_write", 32'(ram_write), 32'd0);
      check("rst_acks", 32'({a_ack, b_ack}), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_addr", 32'(ram_write_address), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);

      // Mapped write from A: ram_write only in cycle 2, ack in cycle 3.
      a_cmd = MWRITE; a_addr = 9'h005; a_wdata = 16'hBEEF;
      exp_q.push_back('{port_b: 1'b0, rdata: 16'h0, err: 1'b0});
      w0 = wr_cnt;
      @(negedge clk);
      check("wr_c2_ram_write", 32'(ram_write), 32'd1);
      check("wr_c2_addr", 32'(ram_write_address), 32'h5);
      check("wr_c2_din", 32'(ram_din), 32'hBEEF);
      check("wr_c2_busy", 32'(busy), 32'd1);
      check("wr_c2_no_ack", 32'(a_ack), 32'd0);
      @(negedge clk);
      check("wr_c3_ram_write", 32'(ram_write), 32'd0);
      check("wr_c3_a_ack", 32'(a_ack), 32'd1);
      check("wr_c3_err", 32'(err), 32'd0);
      a_cmd = MNONE;
      @(negedge clk);
      check("wr_done_busy", 32'(busy), 32'd0);
      check("wr_pulse_count", 32'(wr_cnt - w0), 32'd1);

      // Read back from B.
      b_cmd = MREAD; b_addr = 9'h005;
      exp_q.push_back('{port_b: 1'b1, rdata: 16'hBEEF, err: 1'b0});
      repeat (2) @(negedge clk);
      check("rd_b_ack", 32'(b_ack), 32'd1);
      check("rd_b_rdata", 32'(rdata), 32'hBEEF);
      b_cmd = MNONE;
      @(negedge clk);

      // B writes a second location used later.
      b_cmd = MWRITE; b_addr = 9'h00A; b_wdata = 16'hCAFE;
      exp_q.push_back('{port_b: 1'b1, rdata: 16'h0, err: 1'b0});
      repeat (2) @(negedge clk);
      b_cmd = MNONE;
      @(negedge clk);

      // Unmapped write: no RAM write, ack with err and zero rdata.
      a_cmd = MWRITE; a_addr = 9'h105; a_wdata = 16'h1234;
      exp_q.push_back('{port_b: 1'b0, rdata: 16'h0, err: 1'b1});
      w0 = wr_cnt;
      @(negedge clk);
      check("unm_ram_write", 32'(ram_write), 32'd0);
      @(negedge clk);
      check("unm_a_ack", 32'(a_ack), 32'd1);
      check("unm_err", 32'(err), 32'd1);
      check("unm_rdata", 32'(rdata), 32'd0);
      a_cmd = MNONE;
      @(negedge clk);
      check("unm_no_writes", 32'(wr_cnt - w0), 32'd0);

      // Location 5 must be untouched by the unmapped write.
      a_cmd = MREAD; a_addr = 9'h005;
      exp_q.push_back('{port_b: 1'b0, rdata: 16'hBEEF, err: 1'b0});
      repeat (2) @(negedge clk);
      a_cmd = MNONE;
      @(negedge clk);

      // Reserved command 2'b11 is ignored.
      a_cmd = 2'b11;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("cmd11_busy", 32'(busy), 32'd0);
         check("cmd11_no_ack", 32'(a_ack), 32'd0);
      end
      a_cmd = MNONE;

      // Reset during ACCESS of a write: last grant was A, reset must hand the next tie to A.
      a_cmd = MWRITE; a_addr = 9'h00A; a_wdata = 16'h5555;
      @(negedge clk);
      check("rstw_ram_write_pre", 32'(ram_write), 32'd1);
      reset_n = 1'b0;
      #1;
      check("rstw_ram_write_drop", 32'(ram_write), 32'd0);
      check("rstw_busy", 32'(busy), 32'd0);
      a_cmd = MNONE;
      @(negedge clk);
      check("rstw_no_ack", 32'({a_ack, b_ack}), 32'd0);

      // Both ports read continuously: A,B,A,B,A,B with an ack every third cycle.
      ack_times.delete();
      reset_n = 1'b1;
      a_cmd = MREAD; a_addr = 9'h005;
      b_cmd = MREAD; b_addr = 9'h00A;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back('{port_b: 1'b0, rdata: 16'hBEEF, err: 1'b0});
         exp_q.push_back('{port_b: 1'b1, rdata: 16'hCAFE, err: 1'b0});
      end
      repeat (17) @(negedge clk);
      a_cmd = MNONE; b_cmd = MNONE;
      repeat (3) @(negedge clk);
      check("rr_ack_count", 32'(ack_times.size()), 32'd6);
      for (int i = 1; i < ack_times.size(); i++) begin
         check("rr_ack_spacing", 32'(ack_times[i] - ack_times[i-1]), 32'd3);
      end
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      check("end_busy", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
